mem_sweep_initiator: RTL and testbench

MEM_SWEEP_INITIATOR -- requirements
Module: mem_sweep_initiator

---
 rtl/mem_sweep_initiator_pkg.sv | 22 ++
 rtl/mem_sweep_initiator_if.sv | 36 +++
 rtl/mem_sweep_counter.sv | 39 +++
 rtl/mem_sweep_initiator.sv | 109 ++++++++++
 tb/tb_mem_sweep_initiator.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_sweep_initiator_pkg.sv
// Shared types and constants for the memory sweep initiator.
package mem_sweep_initiator_pkg;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_INC  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A zero count asks for a full sweep of the memory.
    function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] cnt);
        return (cnt == '0) ? CNT_W'(DEPTH) : cnt;
    endfunction

endpackage

// File: rtl/mem_sweep_initiator_if.sv
// Command, memory and response signals of the sweep initiator.
interface mem_sweep_initiator_if;
    import mem_sweep_initiator_pkg::*;

    logic             io_cmd_valid;
    logic             io_cmd_ready;
    logic             io_cmd_mode;
    logic [WIDTH-1:0] io_cmd_base;
    logic [CNT_W-1:0] io_cmd_count;

    logic             io_mem_write;
    logic             io_mem_enable;
    logic [WIDTH-1:0] io_mem_addr;
    logic [WIDTH-1:0] io_mem_out;

    logic             io_rsp_valid;
    logic             io_rsp_ready;
    logic [WIDTH-1:0] io_rsp_sum;

    // Initiator side.
    modport master (
        input  io_cmd_valid, io_cmd_mode, io_cmd_base, io_cmd_count,
        input  io_mem_out, io_rsp_ready,
        output io_cmd_ready, io_mem_write, io_mem_enable, io_mem_addr,
        output io_rsp_valid, io_rsp_sum
    );

    // Command source, memory and response sink side.
    modport slave (
        output io_cmd_valid, io_cmd_mode, io_cmd_base, io_cmd_count,
        output io_mem_out, io_rsp_ready,
        input  io_cmd_ready, io_mem_write, io_mem_enable, io_mem_addr,
        input  io_rsp_valid, io_rsp_sum
    );

endinterface

// File: rtl/mem_sweep_counter.sv
// Sweep index counter with a registered terminal-count flag.
module mem_sweep_counter
    import mem_sweep_initiator_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] limit_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] index_o,
    output logic             tc_o
);

    localparam int unsigned CMP_W = CNT_W + 1;

    logic [CNT_W-1:0] index_q;
    logic [CNT_W-1:0] limit_q;
    logic             tc_q;

    // Restart on load, advance once per issued access; tc_q marks the final index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_q <= '0;
            limit_q <= '0;
            tc_q    <= 1'b0;
        end else if (load_i) begin
            index_q <= '0;
            limit_q <= limit_i;
            tc_q    <= (limit_i == CNT_W'(1));
        end else if (en_i) begin
            index_q <= index_q + CNT_W'(1);
            tc_q    <= ((CMP_W'(index_q) + CMP_W'(2)) == CMP_W'(limit_q));
        end
    end

    assign index_o = index_q;
    assign tc_o    = tc_q;

endmodule

// File: rtl/mem_sweep_initiator.sv
// Sweeps a word range of memory, incrementing or copying each word, and returns
// the sum of the pre-write values. The first RUN cycle registers the first access,
// so the bus sees exactly count access cycles followed by the response.
module mem_sweep_initiator
    import mem_sweep_initiator_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    mem_sweep_initiator_if.master bus
);

    state_e           state_q;
    logic             mode_q;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] sum_q;
    logic             last_q;
    logic             cmd_ready_q;
    logic             mem_write_q;
    logic             mem_enable_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_sum_q;

    logic             accept;
    logic             finish;
    logic             issue;
    logic [CNT_W-1:0] index;
    logic             tc;

    assign accept = (state_q == IDLE) && bus.io_cmd_valid && cmd_ready_q;
    assign finish = mem_write_q && last_q;
    assign issue  = (state_q == RUN) && !finish;

    mem_sweep_counter u_counter (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .limit_i (eff_count(bus.io_cmd_count)),
        .en_i    (issue),
        .index_o (index),
        .tc_o    (tc)
    );

    // Sweep control FSM with registered bus outputs and running sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mode_q       <= MODE_COPY;
            base_q       <= '0;
            sum_q        <= '0;
            last_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            mem_write_q  <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_addr_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_sum_q    <= '0;
        end else begin
            mem_write_q  <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_addr_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mode_q      <= bus.io_cmd_mode;
                        base_q      <= bus.io_cmd_base;
                        sum_q       <= '0;
                        last_q      <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (mem_write_q) begin
                        sum_q <= sum_q + bus.io_mem_out;
                    end
                    if (finish) begin
                        rsp_valid_q <= 1'b1;
                        rsp_sum_q   <= sum_q + bus.io_mem_out;
                        state_q     <= DONE;
                    end else begin
                        mem_write_q  <= 1'b1;
                        mem_enable_q <= (mode_q == MODE_INC);
                        mem_addr_q   <= base_q + WIDTH'(index);
                        last_q       <= tc;
                    end
                end
                DONE: begin
                    if (bus.io_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.io_cmd_ready  = cmd_ready_q;
    assign bus.io_mem_write  = mem_write_q;
    assign bus.io_mem_enable = mem_enable_q;
    assign bus.io_mem_addr   = mem_addr_q;
    assign bus.io_rsp_valid  = rsp_valid_q;
    assign bus.io_rsp_sum    = rsp_sum_q;

endmodule

// File: tb/tb_mem_sweep_initiator.sv
// Bench for mem_sweep_initiator: directed table, randomized sweeps against a
// sequential reference model, stall/back-to-back and mid-sweep reset sequences.
module tb_mem_sweep_initiator;

    logic clk;
    logic reset;

    mem_sweep_initiator_if bus ();

    mem_sweep_initiator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8x32 memory: combinational read, write or preload on the clock.
    logic [31:0] mem      [8];
    logic [31:0] load_img [8];
    logic        load_en;

    assign bus.io_mem_out = mem[bus.io_mem_addr[2:0]];

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 8; i++) mem[i] <= load_img[i];
        end else if (bus.io_mem_write) begin
            if (bus.io_mem_enable)
                mem[bus.io_mem_addr[2:0]] <= mem[bus.io_mem_addr[2:0]] + 32'd1;
            else
                mem[bus.io_mem_addr[2:0]] <= mem[3'(bus.io_mem_addr[2:0] + 3'd4)];
        end
    end

    // Log of every memory write the DUT performs.
    logic [31:0] log_addr [1024];
    logic        log_en   [1024];
    int          n_wr = 0;

    always @(posedge clk) begin
        if (bus.io_mem_write && n_wr < 1024) begin
            log_addr[n_wr] = bus.io_mem_addr;
            log_en[n_wr]   = bus.io_mem_enable;
            n_wr = n_wr + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Reference: words visited in order, each reading its pre-write value.
    logic [31:0] ref_mem [8];

    function automatic logic [31:0] model_sweep(input logic mode, input logic [31:0] base,
                                                input logic [3:0] cnt);
        int          n;
        logic [31:0] s;
        logic [2:0]  a;
        n = (cnt == 4'd0) ? 8 : int'(cnt);
        s = 32'd0;
        for (int k = 0; k < n; k++) begin
            a = 3'(base + 32'(k));
            s = s + ref_mem[a];
            if (mode) ref_mem[a] = ref_mem[a] + 32'd1;
            else      ref_mem[a] = ref_mem[3'(a + 3'd4)];
        end
        return s;
    endfunction

    task automatic load_memory();
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic preload_linear();
        for (int i = 0; i < 8; i++) begin
            load_img[i] = 32'(10 * i);
            ref_mem[i]  = 32'(10 * i);
        end
        load_memory();
    endtask

    // One complete command/response transaction with protocol and latency checks.
    task automatic sweep(input string tag, input logic mode, input logic [31:0] base,
                         input logic [3:0] cnt, input logic [31:0] exp_sum, input int exp_n);
        int   guard;
        int   lat;
        int   start;
        int   bad_en;
        guard = 0;
        while (!bus.io_cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " cmd_ready idle"}, 32'(bus.io_cmd_ready), 32'd1);
        start            = n_wr;
        bus.io_cmd_valid = 1'b1;
        bus.io_cmd_mode  = mode;
        bus.io_cmd_base  = base;
        bus.io_cmd_count = cnt;
        @(negedge clk);
        bus.io_cmd_valid = 1'b0;
        check({tag, " cmd_ready busy"}, 32'(bus.io_cmd_ready), 32'd0);
        lat = 0;
        while (!bus.io_rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_n + 1));
        check({tag, " sum"}, bus.io_rsp_sum, exp_sum);
        check({tag, " writes"}, 32'(n_wr - start), 32'(exp_n));
        if (n_wr > start) begin
            check({tag, " first addr"}, log_addr[start], base);
            check({tag, " last addr"}, log_addr[n_wr - 1], base + 32'(exp_n - 1));
        end
        bad_en = 0;
        for (int k = start; k < n_wr; k++) if (log_en[k] !== mode) bad_en++;
        check({tag, " enable==mode"}, 32'(bad_en), 32'd0);
        bus.io_rsp_ready = 1'b1;
        @(negedge clk);
        bus.io_rsp_ready = 1'b0;
        check({tag, " rsp_valid dropped"}, 32'(bus.io_rsp_valid), 32'd0);
        check({tag, " rsp_sum held"}, bus.io_rsp_sum, exp_sum);
        check({tag, " cmd_ready back"}, 32'(bus.io_cmd_ready), 32'd1);
        check({tag, " idle addr"}, bus.io_mem_addr, 32'd0);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s mem[%0d]", tag, i), mem[i], ref_mem[i]);
    endtask

    typedef struct {
        logic             mode;
        logic [31:0]      base;
        logic [3:0]       cnt;
        logic [31:0]      exp_sum;
        int               exp_n;
        logic [7:0][31:0] exp_mem;   // element 7 listed first
    } vec_t;

    vec_t vecs [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e1;
        logic [31:0] e2;
        logic        mode;
        logic [31:0] base;
        logic [3:0]  cnt;
        int          guard;
        int          start;
        int          stray;

        vecs[0] = '{1'b1, 32'd0, 4'd4, 32'd60,  4,
                    {32'd70, 32'd60, 32'd50, 32'd40, 32'd31, 32'd21, 32'd11, 32'd1}};
        vecs[1] = '{1'b0, 32'd2, 4'd2, 32'd50,  2,
                    {32'd70, 32'd60, 32'd50, 32'd40, 32'd70, 32'd60, 32'd10, 32'd0}};
        vecs[2] = '{1'b1, 32'd6, 4'd4, 32'd140, 4,
                    {32'd71, 32'd61, 32'd50, 32'd40, 32'd30, 32'd20, 32'd11, 32'd1}};
        vecs[3] = '{1'b1, 32'd0, 4'd0, 32'd280, 8,
                    {32'd71, 32'd61, 32'd51, 32'd41, 32'd31, 32'd21, 32'd11, 32'd1}};

        bus.io_cmd_valid = 1'b0;
        bus.io_cmd_mode  = 1'b0;
        bus.io_cmd_base  = 32'd0;
        bus.io_cmd_count = 4'd0;
        bus.io_rsp_ready = 1'b0;
        load_en          = 1'b0;
        for (int i = 0; i < 8; i++) load_img[i] = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset mem_write", 32'(bus.io_mem_write), 32'd0);
        check("reset mem_enable", 32'(bus.io_mem_enable), 32'd0);
        check("reset mem_addr", bus.io_mem_addr, 32'd0);
        check("reset rsp_valid", 32'(bus.io_rsp_valid), 32'd0);
        check("reset rsp_sum", bus.io_rsp_sum, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("reset cmd_ready", 32'(bus.io_cmd_ready), 32'd1);

        // Directed vectors from a linear preload.
        for (int v = 0; v < 4; v++) begin
            preload_linear();
            sweep($sformatf("vec%0d", v), vecs[v].mode, vecs[v].base, vecs[v].cnt,
                  vecs[v].exp_sum, vecs[v].exp_n);
            for (int i = 0; i < 8; i++)
                check($sformatf("vec%0d mem[%0d]", v, i), mem[i], vecs[v].exp_mem[i]);
        end

        // Randomized sweeps against the reference model.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 8; i++) begin
                load_img[i] = $urandom;
                ref_mem[i]  = load_img[i];
            end
            load_memory();
            mode = 1'($urandom_range(0, 1));
            base = $urandom;
            cnt  = 4'($urandom_range(0, 15));
            e1   = model_sweep(mode, base, cnt);
            sweep($sformatf("rand%0d", r), mode, base, cnt, e1, (cnt == 4'd0) ? 8 : int'(cnt));
            check_mem($sformatf("rand%0d", r));
        end

        // Response stall with a competing command, then back-to-back acceptance.
        preload_linear();
        e1    = model_sweep(1'b1, 32'd0, 4'd3);
        e2    = model_sweep(1'b0, 32'd5, 4'd2);
        start = n_wr;
        @(negedge clk);
        bus.io_cmd_valid = 1'b1;
        bus.io_cmd_mode  = 1'b1;
        bus.io_cmd_base  = 32'd0;
        bus.io_cmd_count = 4'd3;
        @(negedge clk);
        bus.io_cmd_valid = 1'b0;
        guard = 0;
        while (!bus.io_rsp_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("stall rsp reached", 32'(bus.io_rsp_valid), 32'd1);
        bus.io_cmd_valid = 1'b1;
        bus.io_cmd_mode  = 1'b0;
        bus.io_cmd_base  = 32'd5;
        bus.io_cmd_count = 4'd2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d rsp_valid", k), 32'(bus.io_rsp_valid), 32'd1);
            check($sformatf("stall%0d rsp_sum", k), bus.io_rsp_sum, e1);
            check($sformatf("stall%0d cmd_ready", k), 32'(bus.io_cmd_ready), 32'd0);
            check($sformatf("stall%0d mem_write", k), 32'(bus.io_mem_write), 32'd0);
        end
        bus.io_rsp_ready = 1'b1;
        @(negedge clk);
        bus.io_rsp_ready = 1'b0;
        check("handshake rsp_valid", 32'(bus.io_rsp_valid), 32'd0);
        check("handshake not yet accepted", 32'(bus.io_cmd_ready), 32'd1);
        check("handshake mem_write", 32'(bus.io_mem_write), 32'd0);
        @(negedge clk);
        bus.io_cmd_valid = 1'b0;
        check("next cmd accepted", 32'(bus.io_cmd_ready), 32'd0);
        guard = 0;
        while (!bus.io_rsp_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("b2b latency", 32'(guard), 32'd3);
        check("b2b sum", bus.io_rsp_sum, e2);
        bus.io_rsp_ready = 1'b1;
        @(negedge clk);
        bus.io_rsp_ready = 1'b0;
        check("b2b writes", 32'(n_wr - start), 32'd5);
        check_mem("b2b");

        // Reset during the second access cycle aborts the sweep.
        preload_linear();
        start = n_wr;
        @(negedge clk);
        bus.io_cmd_valid = 1'b1;
        bus.io_cmd_mode  = 1'b1;
        bus.io_cmd_base  = 32'd0;
        bus.io_cmd_count = 4'd4;
        @(negedge clk);
        bus.io_cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort 2nd access active", 32'(bus.io_mem_write), 32'd1);
        check("abort 2nd access addr", bus.io_mem_addr, 32'd1);
        reset = 1'b1;
        #1;
        check("abort mem_write", 32'(bus.io_mem_write), 32'd0);
        check("abort mem_enable", 32'(bus.io_mem_enable), 32'd0);
        check("abort mem_addr", bus.io_mem_addr, 32'd0);
        check("abort rsp_valid", 32'(bus.io_rsp_valid), 32'd0);
        check("abort rsp_sum", bus.io_rsp_sum, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort cmd_ready", 32'(bus.io_cmd_ready), 32'd1);
        check("abort writes", 32'(n_wr - start), 32'd1);
        check("abort mem[0]", mem[0], 32'd1);
        check("abort mem[1]", mem[1], 32'd10);
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.io_rsp_valid || bus.io_mem_write) stray++;
        end
        check("abort no response", 32'(stray), 32'd0);

        // Normal operation resumes after the abort.
        ref_mem[0] = 32'd1;
        e1 = model_sweep(1'b0, 32'd7, 4'd5);
        sweep("post-reset", 1'b0, 32'd7, 4'd5, e1, 5);
        check_mem("post-reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
